// File: rtl/serial_parity_checker.sv
// serial_parity_checker
// Receive side of the parity-protected serial link. Frames arrive one bit per
// i_bit_valid strobe as: start(0), DATA_W data bits LSB first, parity, stop(1).
// Each completed frame is reported with a one-cycle o_data_valid pulse, together
// with its parity and framing status. Errored frames are reported too.
// A saturating counter tracks how many frames failed the parity check.
module serial_parity_checker #(
  parameter int DATA_W     = 4,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit_valid,
  input  logic              i_serial_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_valid,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_err_count
);

  // Receiver states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // The bit counter only has to reach DATA_W-1, the index of the last data bit.
  localparam int              BC_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Folding the odd/even choice into the XOR: the reduction of data+parity
  // must equal PARITY_ODD for a good frame.
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              r_rx_par;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_parity_err;
  logic              r_frame_err;
  logic [CNT_W-1:0]  r_err_count;

  logic w_stop_strobe;
  logic w_parity_bad;
  logic w_last_bit;

  assign w_stop_strobe = i_bit_valid && (r_state == ST_STOP);
  assign w_parity_bad  = (^r_shift) ^ r_rx_par ^ PAR_ODD;
  assign w_last_bit    = (r_bit_cnt == LAST_BIT);

  // Frame sequencer: walks start -> data -> parity -> stop, advancing only on strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_rx_par  <= 1'b0;
    end else if (i_bit_valid) begin
      case (r_state)
        ST_IDLE: begin
          // A 1 on an idle line is just line idle; only a 0 starts a frame.
          if (!i_serial_in) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          // Shift in from the top so the first data bit ends up in bit 0.
          r_shift   <= {i_serial_in, r_shift[DATA_W-1:1]};
          r_bit_cnt <= r_bit_cnt + BC_ONE;
          if (w_last_bit) begin
            r_state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          r_rx_par <= i_serial_in;
          r_state  <= ST_STOP;
        end
        ST_STOP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Result registers: updated on the stop-bit strobe, valid pulse lasts one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_stop_strobe) begin
        r_data_out   <= r_shift;
        r_data_valid <= 1'b1;
        r_parity_err <= w_parity_bad;
        r_frame_err  <= ~i_serial_in;
        // Counter sticks at all-ones rather than wrapping back to a healthy-looking value.
        if (w_parity_bad && (r_err_count != CNT_MAX)) begin
          r_err_count <= r_err_count + CNT_ONE;
        end
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker
// Drives directed and random frames into an even-parity and an odd-parity
// instance sharing the same serial input, and checks every cycle against a
// frame-level reference model built from a queue of received bits.
module tb_serial_parity_checker;

  localparam int DW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic bv    = 1'b0;
  logic si    = 1'b1;

  logic [DW-1:0] e_data, o_data;
  logic e_valid, e_perr, e_ferr, e_busy;
  logic o_valid, o_perr, o_ferr, o_busy;
  logic [7:0] e_cnt, o_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(0), .CNT_W(8)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_valid(bv), .i_serial_in(si),
    .o_data_out(e_data), .o_data_valid(e_valid), .o_parity_err(e_perr),
    .o_frame_err(e_ferr), .o_busy(e_busy), .o_err_count(e_cnt)
  );

  serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(1), .CNT_W(8)) dut_o (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_valid(bv), .i_serial_in(si),
    .o_data_out(o_data), .o_data_valid(o_valid), .o_parity_err(o_perr),
    .o_frame_err(o_ferr), .o_busy(o_busy), .o_err_count(o_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect sampled bits of the current frame in a queue; a
  // frame is complete once start+data+parity+stop have been collected.
  int         q[$];
  int         m_ones;
  logic [3:0] m_data  = '0;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_perr[2];
  logic [7:0] m_cnt[2];

  // Model update on each active edge, then compare once the DUT has settled
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      for (int p = 0; p < 2; p++) begin
        m_perr[p] = 1'b0;
        m_cnt[p]  = 8'd0;
      end
    end else begin
      m_valid = 1'b0;
      if (bv) begin
        if (q.size() > 0 || si == 1'b0) q.push_back(int'(si));
        if (q.size() == DW + 3) begin
          m_ones = 0;
          for (int k = 0; k < DW; k++) begin
            m_data[k] = (q[1+k] != 0);
            m_ones += q[1+k];
          end
          m_ones += q[DW+1];
          for (int p = 0; p < 2; p++) begin
            m_perr[p] = ((m_ones % 2) != p);
            if (m_perr[p] && m_cnt[p] != 8'hFF) m_cnt[p] = m_cnt[p] + 8'd1;
          end
          m_ferr  = (q[DW+2] == 0);
          m_valid = 1'b1;
          q.delete();
          $display("frame data=%h perr_even=%0d perr_odd=%0d ferr=%0d cnt_even=%0d cnt_odd=%0d",
                   m_data, m_perr[0], m_perr[1], m_ferr, m_cnt[0], m_cnt[1]);
        end
      end
    end
    #1;
    chk("e_data_out",   32'(e_data),  32'(m_data));
    chk("e_data_valid", 32'(e_valid), 32'(m_valid));
    chk("e_parity_err", 32'(e_perr),  32'(m_perr[0]));
    chk("e_frame_err",  32'(e_ferr),  32'(m_ferr));
    chk("e_busy",       32'(e_busy),  32'(q.size() != 0));
    chk("e_err_count",  32'(e_cnt),   32'(m_cnt[0]));
    chk("o_data_out",   32'(o_data),  32'(m_data));
    chk("o_data_valid", 32'(o_valid), 32'(m_valid));
    chk("o_parity_err", 32'(o_perr),  32'(m_perr[1]));
    chk("o_frame_err",  32'(o_ferr),  32'(m_ferr));
    chk("o_busy",       32'(o_busy),  32'(q.size() != 0));
    chk("o_err_count",  32'(o_cnt),   32'(m_cnt[1]));
  end

  // One serial bit, optionally preceded by up to gmax idle (no-strobe) cycles
  task automatic send_bit(input logic b, input int gmax);
    int g;
    g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      bv = 1'b0;
      si = 1'($urandom);
    end
    @(negedge clk);
    bv = 1'b1;
    si = b;
  endtask

  // Whole frame; tail=1 drops the strobe in the result cycle, skip_start
  // assumes the caller already drove the start bit.
  task automatic send_frame(input logic [3:0] d, input logic par, input logic stop,
                            input int gmax, input bit tail, input bit skip_start);
    if (!skip_start) send_bit(1'b0, gmax);
    for (int k = 0; k < DW; k++) send_bit(d[k], gmax);
    send_bit(par, gmax);
    send_bit(stop, gmax);
    if (tail) begin
      @(negedge clk);
      bv = 1'b0;
    end
  endtask

  // Literal result expectations for the even-parity instance
  task automatic pin_e(input string tag, input logic [3:0] d, input logic pe,
                       input logic fe, input logic [7:0] cnt);
    chk({tag, "_valid"}, 32'(e_valid), 32'd1);
    chk({tag, "_data"},  32'(e_data),  32'(d));
    chk({tag, "_perr"},  32'(e_perr),  32'(pe));
    chk({tag, "_ferr"},  32'(e_ferr),  32'(fe));
    chk({tag, "_cnt"},   32'(e_cnt),   32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [3:0] d;
    logic       par;
    logic       stop;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(e_data),  32'd0);
    chk("rst_busy",  32'(e_busy),  32'd0);
    chk("rst_cnt",   32'(e_cnt),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good even-parity frame 4'hB
    send_frame(4'hB, 1'b1, 1'b1, 0, 1, 0);
    pin_e("good_B", 4'hB, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    chk("good_B_pulse_drop", 32'(e_valid), 32'd0);

    // Parity flipped, then a clean frame 4'h0
    send_frame(4'hB, 1'b0, 1'b1, 0, 1, 0);
    pin_e("bad_B", 4'hB, 1'b1, 1'b0, 8'd1);
    send_frame(4'h0, 1'b0, 1'b1, 0, 1, 0);
    pin_e("good_0", 4'h0, 1'b0, 1'b0, 8'd1);

    // Stop bit 0, then a start bit in the very next cycle
    send_frame(4'h5, 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    bv = 1'b1;
    si = 1'b0;
    pin_e("ferr_5", 4'h5, 1'b0, 1'b1, 8'd1);

    // Continue that frame as 4'hC with random gaps inside
    send_frame(4'hC, 1'b0, 1'b1, 5, 1, 1);
    pin_e("gap_C", 4'hC, 1'b0, 1'b0, 8'd1);

    // Reset after two data bits: aborts the frame, outputs clear at once
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    @(negedge clk);
    bv    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_data",  32'(e_data),  32'd0);
    chk("arst_valid", 32'(e_valid), 32'd0);
    chk("arst_busy",  32'(e_busy),  32'd0);
    chk("arst_cnt",   32'(e_cnt),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 4'h7 with parity 0: wrong for even, right for odd
    send_frame(4'h7, 1'b0, 1'b1, 0, 1, 0);
    pin_e("after_rst_7", 4'h7, 1'b1, 1'b0, 8'd1);
    chk("odd_7_perr", 32'(o_perr), 32'd0);
    chk("odd_7_data", 32'(o_data), 32'h7);
    chk("odd_7_cnt",  32'(o_cnt),  32'd0);

    // Random traffic: idle ones, gaps, back-to-back frames, bad parity/stop
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(2, 0)) send_bit(1'b1, 1);
      d    = 4'($urandom);
      par  = ^d;
      if ($urandom_range(4, 0) == 0) par = ~par;
      stop = ($urandom_range(9, 0) != 0);
      send_frame(d, par, stop, 3, bit'($urandom_range(1, 0)), 0);
    end
    @(negedge clk);
    bv = 1'b0;

    // Saturation of the even counter
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 255; n++) begin
      d = 4'($urandom);
      send_frame(d, ~(^d), 1'b1, 0, 0, 0);
    end
    @(negedge clk);
    bv = 1'b0;
    chk("sat_255", 32'(e_cnt), 32'hFF);
    for (int n = 0; n < 3; n++) begin
      d = 4'($urandom);
      send_frame(d, ~(^d), 1'b1, 0, 1, 0);
      chk("sat_hold_perr", 32'(e_perr), 32'd1);
      chk("sat_hold_cnt",  32'(e_cnt),  32'hFF);
    end
    chk("sat_odd_cnt", 32'(o_cnt), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Receiving end of the team's 4-bit parity-protected link: the parity checker that pairs with the parity generator.
- Deserialises framed bits (start, DATA_W data LSB-first, parity, stop) presented one per bit_valid strobe.
- Recomputes parity, flags parity and framing errors, and presents the recovered word with a one-cycle valid pulse.
- Keeps a saturating parity-error counter for link-health monitoring.

Parameters:
- DATA_W, 4, number of data bits per frame (legal range 2..16).
- PARITY_ODD, 0, 0 = even parity (data bits plus parity bit contain an even number of 1s); 1 = odd parity.
- CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_valid  in  1  qualifies serial_in for this cycle; gaps between strobes are allowed.
- serial_in  in  1  serial frame bit; sampled only when bit_valid=1.
- data_out  out  DATA_W  last received word; held until the next frame completes.
- data_valid  out  1  one-cycle pulse when a frame completes, including errored frames.
- parity_err  out  1  parity mismatch for the frame; valid with data_valid and held until the next completion.
- frame_err  out  1  stop bit was 0; valid with data_valid and held until the next completion.
- busy  out  1  high while the FSM is not in IDLE.
- err_count  out  CNT_W  number of frames with parity_err=1; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - data_out, data_valid, parity_err, frame_err, busy and err_count all reset to 0.
  - Internal shift register and bit counter are cleared.
- All sampling is qualified by bit_valid. Cycles with bit_valid=0 change no state except that the data_valid pulse drops.
- FSM states:
  - IDLE: bit_valid=1 and serial_in=0 (start bit) moves to DATA and clears the bit counter. bit_valid=1 with serial_in=1 is an idle line and the FSM stays in IDLE.
  - DATA: each strobe shifts serial_in into the shift register, LSB first (first data bit lands in bit 0). After DATA_W strobes the FSM moves to PARITY.
  - PARITY: one strobe captures rx_par and moves to STOP.
  - STOP: one strobe completes the frame and returns to IDLE. On that edge:
    - data_out <= shift register.
    - parity_err <= (^shift ^ rx_par) != PARITY_ODD.
    - frame_err <= ~serial_in.
    - data_valid <= 1 for exactly one cycle.
    - err_count increments if parity_err is set and err_count has not saturated.
- Latency: data_valid is high in the cycle after the clock edge that samples the stop bit.
- A start bit sampled in the cycle immediately after the stop bit is accepted. Back-to-back frames need no idle bits.
- A frame with frame_err=1 is still reported. Its data and parity result are delivered and the FSM returns to IDLE. There is no resynchronisation search.
- err_count holds at 2^CNT_W-1 once saturated; it never wraps.
- rst_n asserted mid-frame aborts the frame with no data_valid pulse, and all outputs go to their reset values.
- busy = (state != IDLE), decoded from registered state.

Test Plan:
- Even parity, data 4'b1011: strobes 0,1,1,0,1,1(parity),1(stop) -> the next cycle shows data_out=4'hB, data_valid=1 for one cycle, parity_err=0, frame_err=0, err_count=0.
- Same frame with the parity bit flipped to 0 -> data_out=4'hB, parity_err=1, err_count=1. A following good frame 4'h0 (parity 0) leaves parity_err=0 and err_count=1.
- Stop bit sent as 0 for data 4'h5 (parity 0) -> data_valid=1, data_out=4'h5, frame_err=1, parity_err=0. The FSM is back in IDLE and accepts the next start bit.
- Random gaps of 0-5 cycles with bit_valid=0 inside a frame carrying 4'hC -> result identical to the gapless case, and busy stays high for the whole frame.
- Reset asserted after 2 data bits -> no data_valid pulse, and all outputs are 0 immediately while rst_n=0. A full frame 4'h7 after release decodes correctly. With PARITY_ODD=1, 4'h7 with parity bit 0 gives parity_err=0.
- Force 256 parity-error frames with CNT_W=8 -> err_count stops at 8'hFF and stays there on the 256th and later errors.
